// File: rtl/irq_pend_latch_if.sv
// Request/service bundle between the pending latch and its driver/consumer.
interface irq_pend_latch_if #(
    parameter int unsigned MISS_W = 4
);
    logic [3:0]        irq_in;
    logic [3:0]        mask;
    logic              ack;
    logic [1:0]        ack_idx;
    logic              clr_miss;
    logic [3:0]        req;
    logic [3:0]        pending;
    logic [MISS_W-1:0] miss_cnt;
    logic              miss_flag;

    modport master (
        output irq_in, mask, ack, ack_idx, clr_miss,
        input  req, pending, miss_cnt, miss_flag
    );

    modport slave (
        input  irq_in, mask, ack, ack_idx, clr_miss,
        output req, pending, miss_cnt, miss_flag
    );
endinterface

// File: rtl/irq_pend_latch.sv
// Sticky interrupt pending latch with edge detect, ack-by-index and lost-event counter.
// Optional IRQ_SYNC_EN adds a two-flop synchroniser per source in front of the edge detector.
module irq_pend_latch #(
    parameter int unsigned MISS_W = 4
) (
    input logic              Clock,
    input logic              Reset_n,
    irq_pend_latch_if.slave  bus
);
    localparam int unsigned N_SRC = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    logic [N_SRC-1:0]  s;
    logic [N_SRC-1:0]  prev;
    logic [N_SRC-1:0]  pending_q;
    logic [N_SRC-1:0]  pending_d;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  clr;
    logic [N_SRC-1:0]  lost;
    logic [MISS_W-1:0] miss_cnt_q;
    logic [MISS_W-1:0] miss_cnt_d;
    logic [MISS_W-1:0] cnt_base;
    logic              miss_flag_q;
    logic              miss_flag_d;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    // Two-flop synchroniser for asynchronous sources
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = bus.irq_in;
`endif

    // Edge detect, ack decode, pending and miss next-state
    always_comb begin
        rise        = s & ~prev;
        clr         = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            clr[i] = bus.ack && (bus.ack_idx == IDX_W'(i));
        end
        lost        = rise & pending_q & ~clr;
        pending_d   = (pending_q & ~clr) | rise;

        // clr_miss clears first, then a same-cycle loss counts from zero
        cnt_base    = bus.clr_miss ? '0 : miss_cnt_q;
        miss_cnt_d  = cnt_base;
        miss_flag_d = bus.clr_miss ? 1'b0 : miss_flag_q;
        if (|lost) begin
            miss_flag_d = 1'b1;
            if (cnt_base != MISS_MAX) begin
                miss_cnt_d = cnt_base + MISS_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            prev        <= '0;
            pending_q   <= '0;
            miss_cnt_q  <= '0;
            miss_flag_q <= 1'b0;
        end else begin
            prev        <= s;
            pending_q   <= pending_d;
            miss_cnt_q  <= miss_cnt_d;
            miss_flag_q <= miss_flag_d;
        end
    end

    assign bus.req       = pending_q & bus.mask;
    assign bus.pending   = pending_q;
    assign bus.miss_cnt  = miss_cnt_q;
    assign bus.miss_flag = miss_flag_q;
endmodule

// File: tb/tb_irq_pend_latch.sv
// Directed self-checking bench for irq_pend_latch (default and MISS_W=2 instances share stimulus).
module tb_irq_pend_latch;
`ifdef IRQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       clr_miss;
    int         n_vec;
    int         n_err;

    irq_pend_latch_if #(.MISS_W(4)) bus4 ();
    irq_pend_latch_if #(.MISS_W(2)) bus2 ();

    assign bus4.irq_in   = irq_in;
    assign bus4.mask     = mask;
    assign bus4.ack      = ack;
    assign bus4.ack_idx  = ack_idx;
    assign bus4.clr_miss = clr_miss;
    assign bus2.irq_in   = irq_in;
    assign bus2.mask     = mask;
    assign bus2.ack      = ack;
    assign bus2.ack_idx  = ack_idx;
    assign bus2.clr_miss = clr_miss;

    irq_pend_latch #(.MISS_W(4)) u_dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus4)
    );

    irq_pend_latch #(.MISS_W(2)) u_sat (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive bits so their rising edge lands on the edge where ack/clr_miss are applied, then idle a cycle
    task automatic fire(input logic [3:0] bits, input logic do_ack, input logic [1:0] idx,
                        input logic clrm);
        irq_in = bits;
        for (int k = 0; k < SL; k++) begin
            tick(1);
            irq_in = '0;
        end
        ack      = do_ack;
        ack_idx  = idx;
        clr_miss = clrm;
        tick(1);
        ack      = 1'b0;
        clr_miss = 1'b0;
        irq_in   = '0;
        tick(1);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        irq_in   = 4'b1010;
        mask     = 4'b1111;
        ack      = 1'b0;
        ack_idx  = 2'd0;
        clr_miss = 1'b0;

        tick(3);
        check("rst_req", 32'(bus4.req), 32'h0);
        check("rst_pending", 32'(bus4.pending), 32'h0);
        check("rst_miss_cnt", 32'(bus4.miss_cnt), 32'h0);
        check("rst_miss_flag", 32'(bus4.miss_flag), 32'h0);

        rst_n = 1'b1;
        tick(1 + SL);
        check("release_pending", 32'(bus4.pending), 32'ha);
        check("release_req", 32'(bus4.req), 32'ha);

        ack = 1'b1; ack_idx = 2'd3;
        tick(1);
        check("ack3_pending", 32'(bus4.pending), 32'h2);
        ack_idx = 2'd0;
        tick(1);
        check("ack_nonpend", 32'(bus4.pending), 32'h2);
        ack_idx = 2'd1;
        tick(1);
        ack = 1'b0;
        tick(1 + SL);
        check("level_held_no_repend", 32'(bus4.pending), 32'h0);
        irq_in = '0;
        tick(2 + SL);

        mask = 4'b1011;
        fire(4'b0100, 1'b0, 2'd0, 1'b0);
        check("masked_pending", 32'(bus4.pending), 32'h4);
        check("masked_req", 32'(bus4.req), 32'h0);
        mask = 4'b1111;
        #1;
        check("unmask_req", 32'(bus4.req), 32'h4);
        ack = 1'b1; ack_idx = 2'd2;
        tick(1);
        ack = 1'b0;
        check("ack2_pending", 32'(bus4.pending), 32'h0);

        fire(4'b0010, 1'b0, 2'd0, 1'b0);
        check("src1_pending", 32'(bus4.pending), 32'h2);
        fire(4'b0010, 1'b1, 2'd1, 1'b0);
        check("collide_pending", 32'(bus4.pending), 32'h2);
        check("collide_miss_cnt", 32'(bus4.miss_cnt), 32'h0);
        check("collide_miss_flag", 32'(bus4.miss_flag), 32'h0);

        fire(4'b0001, 1'b0, 2'd0, 1'b0);
        check("src0_pending", 32'(bus4.pending), 32'h3);
        fire(4'b0001, 1'b0, 2'd0, 1'b0);
        fire(4'b0001, 1'b0, 2'd0, 1'b0);
        fire(4'b0001, 1'b0, 2'd0, 1'b0);
        check("miss3_cnt", 32'(bus4.miss_cnt), 32'h3);
        check("miss3_flag", 32'(bus4.miss_flag), 32'h1);
        check("miss3_sat_cnt", 32'(bus2.miss_cnt), 32'h3);

        fire(4'b0101, 1'b0, 2'd0, 1'b0);
        check("miss4_pending", 32'(bus4.pending), 32'h7);
        check("miss4_cnt", 32'(bus4.miss_cnt), 32'h4);
        fire(4'b0101, 1'b0, 2'd0, 1'b0);
        check("dual_lost_cnt", 32'(bus4.miss_cnt), 32'h5);
        check("sat_cnt", 32'(bus2.miss_cnt), 32'h3);
        check("sat_flag", 32'(bus2.miss_flag), 32'h1);

        clr_miss = 1'b1;
        tick(1);
        clr_miss = 1'b0;
        check("clr_cnt", 32'(bus4.miss_cnt), 32'h0);
        check("clr_flag", 32'(bus4.miss_flag), 32'h0);
        check("clr_sat_cnt", 32'(bus2.miss_cnt), 32'h0);

        fire(4'b0001, 1'b0, 2'd0, 1'b1);
        check("clr_lost_cnt", 32'(bus4.miss_cnt), 32'h1);
        check("clr_lost_flag", 32'(bus4.miss_flag), 32'h1);
        check("clr_lost_sat_cnt", 32'(bus2.miss_cnt), 32'h1);

        fire(4'b1000, 1'b0, 2'd0, 1'b0);
        fire(4'b0001, 1'b0, 2'd0, 1'b0);
        check("pre_rst_pending", 32'(bus4.pending), 32'hf);
        check("pre_rst_cnt", 32'(bus4.miss_cnt), 32'h2);

        mask = 4'b0000;
        #1;
        check("mask_all_req", 32'(bus4.req), 32'h0);
        ack = 1'b1; ack_idx = 2'd3;
        tick(1);
        ack = 1'b0;
        check("ack_masked_pending", 32'(bus4.pending), 32'h7);
        mask = 4'b1111;
        fire(4'b1000, 1'b0, 2'd0, 1'b0);
        check("repend3_req", 32'(bus4.req), 32'hf);

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_pending", 32'(bus4.pending), 32'h0);
        check("midrst_req", 32'(bus4.req), 32'h0);
        check("midrst_cnt", 32'(bus4.miss_cnt), 32'h0);
        check("midrst_flag", 32'(bus4.miss_flag), 32'h0);
        tick(4);
        check("post_rst_idle", 32'(bus4.pending), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
